// File: rtl/conv_pkg.sv
// Shared conv-layer constants, the ofm channel-vector type and the
// state encoding of the conv1 output-feature-map writer.
package conv_pkg;

    localparam int WIDTH  = 16;
    localparam int DSP_NO = 64;
    localparam int W_OUT  = 128;
    localparam int H_OUT  = 128;
    localparam int BANKS  = 4;

    typedef logic [WIDTH-1:0] ofm_vec_t [0:DSP_NO-1];

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        DONE
    } ofm_wr_state_t;

endpackage

// File: rtl/conv1_ofm_writer_addr_gen.sv
// ofm_addr_gen: group / pixel counters and the shared bank address.
// Ports: clk, rst (async high), clr (restart), load (new pixel),
//   step (one group written) -> grp, pix_idx, addr, last_grp, last_pix.
module ofm_addr_gen #(
    parameter int GROUPS = 16,
    parameter int PIX    = 16384,
    parameter int ADDR_W = 18,
    parameter int GRP_W  = 4,
    parameter int PIX_W  = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              load,
    input  logic              step,
    output logic [GRP_W-1:0]  grp,
    output logic [PIX_W-1:0]  pix_idx,
    output logic [ADDR_W-1:0] addr,
    output logic              last_grp,
    output logic              last_pix
);
    import conv_pkg::*;

    assign last_grp = (grp == GRP_W'(GROUPS - 1));
    assign last_pix = (pix_idx == PIX_W'(PIX - 1));

    // Channel-major: each group owns a PIX-sized slice of every bank.
    assign addr = ADDR_W'(grp) * ADDR_W'(PIX) + ADDR_W'(pix_idx);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grp     <= '0;
            pix_idx <= '0;
        end else if (clr) begin
            grp     <= '0;
            pix_idx <= '0;
        end else if (load) begin
            grp <= '0;
        end else if (step) begin
            grp <= last_grp ? '0 : grp + 1'b1;
            // Final pixel holds its index; DONE stops further steps.
            if (last_grp && !last_pix) begin
                pix_idx <= pix_idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/conv1_ofm_writer.sv
// conv1 ofm writer: captures one 64-channel pixel vector and drains it
// into BANKS parallel RAM banks, GROUPS registered writes per pixel.
// Ports: clk, rst (async high), start, ofm_valid/ofm_in/ofm_ready,
//   wr_en/wr_addr/wr_data (bank write port), pix_idx, layer_done,
//   err_overrun. Build option CONV1_OFM_WRITER_RELU_EN zeroes negative
//   channels at capture; otherwise data passes bit-exact.
module conv1_ofm_writer #(
    parameter int DSP_NO = conv_pkg::DSP_NO,
    parameter int WIDTH  = conv_pkg::WIDTH,
    parameter int W_OUT  = conv_pkg::W_OUT,
    parameter int H_OUT  = conv_pkg::H_OUT,
    parameter int BANKS  = conv_pkg::BANKS,
    parameter int GROUPS = DSP_NO / BANKS,
    parameter int PIX    = W_OUT * H_OUT,
    parameter int ADDR_W = $clog2(GROUPS * PIX)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    ofm_valid,
    input  logic [WIDTH-1:0]        ofm_in [0:DSP_NO-1],
    output logic                    ofm_ready,
    output logic [BANKS-1:0]        wr_en,
    output logic [ADDR_W-1:0]       wr_addr,
    output logic [WIDTH-1:0]        wr_data [0:BANKS-1],
    output logic [$clog2(PIX)-1:0]  pix_idx,
    output logic                    layer_done,
    output logic                    err_overrun
);
    import conv_pkg::*;

    localparam int GRP_W = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int CH_W  = (DSP_NO > 1) ? $clog2(DSP_NO) : 1;

    ofm_wr_state_t state_q;
    ofm_wr_state_t state_d;

    logic [WIDTH-1:0]  buf_q [0:DSP_NO-1];
    logic [WIDTH-1:0]  sel   [0:BANKS-1];
    logic [GRP_W-1:0]  grp;
    logic [ADDR_W-1:0] addr;
    logic              last_grp;
    logic              last_pix;
    logic              capture;
    logic              step;

    ofm_addr_gen #(
        .GROUPS (GROUPS),
        .PIX    (PIX),
        .ADDR_W (ADDR_W),
        .GRP_W  (GRP_W),
        .PIX_W  ($clog2(PIX))
    ) u_addr (
        .clk      (clk),
        .rst      (rst),
        .clr      (start),
        .load     (capture),
        .step     (step),
        .grp      (grp),
        .pix_idx  (pix_idx),
        .addr     (addr),
        .last_grp (last_grp),
        .last_pix (last_pix)
    );

    assign ofm_ready  = (state_q == IDLE);
    assign layer_done = (state_q == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // start wins over everything, including a same-cycle strobe.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        step    = 1'b0;
        if (start) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (ofm_valid) begin
                        capture = 1'b1;
                        state_d = DRAIN;
                    end
                end
                DRAIN: begin
                    step = 1'b1;
                    if (last_grp) begin
                        state_d = last_pix ? DONE : IDLE;
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < DSP_NO; c++) begin
                buf_q[c] <= '0;
            end
        end else if (capture) begin
            for (int c = 0; c < DSP_NO; c++) begin
`ifdef CONV1_OFM_WRITER_RELU_EN
                buf_q[c] <= ofm_in[c][WIDTH-1] ? '0 : ofm_in[c];
`else
                buf_q[c] <= ofm_in[c];
`endif
            end
        end
    end

    // Bank b of group g carries channel g*BANKS+b.
    always_comb begin
        for (int b = 0; b < BANKS; b++) begin
            sel[b] = buf_q[CH_W'(int'(grp) * BANKS + b)];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en   <= '0;
            wr_addr <= '0;
            for (int b = 0; b < BANKS; b++) begin
                wr_data[b] <= '0;
            end
        end else if (step) begin
            wr_en   <= '1;
            wr_addr <= addr;
            for (int b = 0; b < BANKS; b++) begin
                wr_data[b] <= sel[b];
            end
        end else begin
            wr_en <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_overrun <= 1'b0;
        end else if (start) begin
            err_overrun <= 1'b0;
        end else if (ofm_valid && !ofm_ready) begin
            err_overrun <= 1'b1;
        end
    end

endmodule

// File: doc/conv1_ofm_writer.md
# conv1_ofm_writer

Receives the 64-channel output vector that the first convolution layer emits once per output pixel. Holds the vector in a one-entry capture buffer and drains it into `BANKS` parallel 16-bit single-port feature-map RAM banks, using a channel-major layout. Tracks the pixel position across the 128×128 output plane and flags completion. Sits between the conv1 MAC array and the feature-map memory read by the next layer.

## Interface
- `DSP_NO`, default 64: channels per output pixel (ofm vector length).
- `WIDTH`, default 16: data width per channel.
- `W_OUT`, default 128: output plane width.
- `H_OUT`, default 128: output plane height.
- `BANKS`, default 4: parallel RAM banks; must divide `DSP_NO`.
- `GROUPS`, default `DSP_NO/BANKS` (16): write cycles per pixel.
- `PIX`, default `W_OUT*H_OUT` (16384): pixels per plane.
- `ADDR_W`, default `$clog2(GROUPS*PIX)` (18): bank address width.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: synchronous restart of a layer pass.
- `ofm_valid`, in, 1: one-cycle strobe; `ofm_in` is valid this cycle.
- `ofm_in`, in, `[WIDTH-1:0] [0:DSP_NO-1]`: channel vector.
- `ofm_ready`, out, 1: capture buffer free.
- `wr_en`, out, `[BANKS-1:0]`: bank write enables.
- `wr_addr`, out, `ADDR_W`: address shared by all banks.
- `wr_data`, out, `[WIDTH-1:0] [0:BANKS-1]`: per-bank write data.
- `pix_idx`, out, `$clog2(PIX)`: index of the next pixel to be written.
- `layer_done`, out, 1: all `PIX` pixels written.
- `err_overrun`, out, 1: sticky flag; a strobe arrived while not ready.

## Operation
- FSM states: IDLE, DRAIN, DONE.
- **IDLE** (`ofm_ready`=1):
  - On `ofm_valid`, latch `ofm_in` into the capture buffer, clear `grp` to 0, go to DRAIN.
- **DRAIN** (`ofm_ready`=0):
  - Each cycle write group `grp`: bank b receives channel `grp*BANKS+b`.
  - Address is `grp*PIX + pix_idx`; all `wr_en` bits are high.
  - `grp` increments each cycle.
  - At `grp==GROUPS-1`, `pix_idx` increments. Go to DONE if `pix_idx==PIX-1`, else to IDLE.
- **DONE**: `layer_done`=1, `ofm_ready`=0, no writes.
- Overrun: `ofm_valid` while `ofm_ready`=0 sets `err_overrun`. The sample is dropped and the buffer is untouched.
- `start`, in any state: go to IDLE; clear `pix_idx`, `grp`, `layer_done`, `err_overrun`.
  - `start` has priority over `ofm_valid` in the same cycle. That sample is dropped without flagging.
  - `start` during DRAIN abandons the remaining groups of the current pixel.
- Address arithmetic: `grp*PIX` is a constant shift when `PIX` is a power of two. No wrap: `pix_idx` saturates via DONE.
- Reset values:
  - `ofm_ready`=1, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `pix_idx`=0, `layer_done`=0, `err_overrun`=0.
  - FSM=IDLE; the capture buffer is cleared.
- Reset mid-DRAIN discards the partial pixel. Already-written groups remain in RAM.

## Timing
- `wr_en`, `wr_addr`, and `wr_data` are registered outputs.
- A strobe sampled at edge N produces writes in cycles N+1 through N+GROUPS.
- `ofm_ready` returns high in the cycle after the last group write.
- Throughput: one pixel per `GROUPS+1` cycles (17). This is under the 28-cycle conv1 output period, so overrun never occurs in normal operation.
- `layer_done` rises in the cycle after the final write of pixel `PIX-1`.
- `ofm_ready` is a pure function of state (no combinational path from `ofm_valid`).

## Configuration
- `CONV1_OFM_WRITER_RELU_EN`
  - Defined: at capture, any channel with bit `WIDTH-1` set is stored as 0.
  - Undefined: values pass through bit-exact.

## Structure
- Shared package `conv_pkg`:
  - `WIDTH`, `DSP_NO`, `W_OUT`, `H_OUT`, `BANKS`.
  - Typedef `ofm_vec_t`, i.e. `logic [WIDTH-1:0] [0:DSP_NO-1]`.
  - Enum `ofm_wr_state_t` {IDLE, DRAIN, DONE}.
- One sub-module: `ofm_addr_gen`, holding the `grp`/`pix_idx` counters and the address computation. It exposes `last_grp` and `last_pix` strobes.

## Test plan
- **Single pixel:** reset, then strobe channels `ofm_in[c]=c+1` → 16 write cycles.
  - Cycle 1: banks 0–3 get 1–4 at addr 0.
  - Cycle 16: banks get 61–64 at addr `15*16384`.
  - `ofm_ready` is high again at cycle 17.
- **Back-to-back at period 17:** 3 pixels → `pix_idx`=3; the third pixel's group 0 is at addr 2; `err_overrun`=0.
- **Overrun:** a strobe 5 cycles after the previous strobe → `err_overrun`=1; the first pixel's data is written intact and `pix_idx` advances by 1 only.
- **Full plane:** 16384 strobes at period 28 → `layer_done`=1 after the final write to addr 262143; a further strobe sets `err_overrun`.
- **Restart:** `start` during DRAIN at `grp`=7, with a simultaneous strobe → IDLE, `pix_idx`=0, no flag; then the next strobe writes addr 0.
- **ReLU:** with `CONV1_OFM_WRITER_RELU_EN`, channel 2 = 16'h8001 → bank 2 writes 0. Without it, bank 2 writes 16'h8001.
